// File: rtl/uart_link_ctrl.sv
// Link-configuration sequencer and RX frame buffer between host and UART datapaths.
// Optional build macro UART_LINK_CTRL_FLUSH_ON_CFG_EN: empty the RX FIFO when a new config is applied.
module uart_link_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int RST_PRESCALE   = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int ERR_CNT_WIDTH  = 8,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      cfg_wr,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
    input  logic                      cfg_par_en,
    input  logic                      cfg_par_typ,
    output logic                      cfg_busy,
    input  logic                      rx_busy,
    input  logic                      tx_busy,
    output logic                      link_en,
    output logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      PAR_EN,
    output logic                      PAR_TYP,
    input  logic                      rx_frame_stb,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    input  logic                      rx_par_err,
    input  logic                      rx_stp_err,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      overflow,
    output logic [ERR_CNT_WIDTH-1:0]  par_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0]  stp_err_cnt,
    input  logic                      err_clr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
`ifdef UART_LINK_CTRL_FLUSH_ON_CFG_EN
    localparam bit FLUSH_ON_CFG = 1'b1;
`else
    localparam bit FLUSH_ON_CFG = 1'b0;
`endif

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_APPLY, S_SETTLE} state_t;

    state_t                    state, state_nxt;
    logic [SET_W-1:0]          settle_cnt;
    logic [PRESCALE_WIDTH-1:0] sh_prescale;
    logic                      sh_par_en, sh_par_typ;

    always_comb begin
        state_nxt = state;
        link_en   = 1'b0;
        cfg_busy  = 1'b1;
        case (state)
            S_RUN: begin
                link_en  = 1'b1;
                cfg_busy = 1'b0;
                if (cfg_wr) state_nxt = S_DRAIN;
            end
            S_DRAIN:  if (!rx_busy && !tx_busy) state_nxt = S_APPLY;
            S_APPLY:  state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) state_nxt = S_RUN;
            default:  state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_RUN;
            settle_cnt  <= '0;
            sh_prescale <= '0;
            sh_par_en   <= 1'b0;
            sh_par_typ  <= 1'b0;
            PRESCALE    <= PRESCALE_WIDTH'(RST_PRESCALE);
            PAR_EN      <= 1'b0;
            PAR_TYP     <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + SET_W'(1) : '0;
            // Shadow accepts writes until APPLY; last write wins during DRAIN
            if (cfg_wr && (state == S_RUN || state == S_DRAIN)) begin
                sh_prescale <= cfg_prescale;
                sh_par_en   <= cfg_par_en;
                sh_par_typ  <= cfg_par_typ;
            end
            if (state == S_APPLY) begin
                PRESCALE <= sh_prescale;
                PAR_EN   <= sh_par_en;
                PAR_TYP  <= sh_par_typ;
            end
        end
    end

    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  good, full, pop, push, flush;

    assign good     = rx_frame_stb && !rx_par_err && !rx_stp_err;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign push     = good && (!full || pop);
    assign flush    = FLUSH_ON_CFG && (state == S_APPLY);
    // Empty FIFO keeps presenting whatever was last on rd_data
    assign rd_data  = rd_valid ? mem[rd_ptr] : hold_q;

    always_ff @(posedge CLK) begin
        if (push && !flush) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            hold_q <= rd_data;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || err_clr) begin
            overflow    <= 1'b0;
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else begin
            if (good && !push && !flush) overflow <= 1'b1;
            if (rx_frame_stb && rx_par_err && par_err_cnt != '1)
                par_err_cnt <= par_err_cnt + ERR_CNT_WIDTH'(1);
            if (rx_frame_stb && rx_stp_err && stp_err_cnt != '1)
                stp_err_cnt <= stp_err_cnt + ERR_CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl: config sequencing, FIFO intake/overflow, error counters.
module tb_uart_link_ctrl;
    logic       CLK, RST;
    logic       cfg_wr, cfg_par_en, cfg_par_typ, cfg_busy;
    logic [5:0] cfg_prescale, PRESCALE;
    logic       rx_busy, tx_busy, link_en, PAR_EN, PAR_TYP;
    logic       rx_frame_stb, rx_par_err, rx_stp_err;
    logic [7:0] rx_data, rd_data, par_err_cnt, stp_err_cnt;
    logic       rd_valid, rd_ready, overflow, err_clr;

    int n_cmp = 0;
    int n_bad = 0;

    uart_link_ctrl dut (
        .CLK(CLK), .RST(RST),
        .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
        .cfg_par_typ(cfg_par_typ), .cfg_busy(cfg_busy),
        .rx_busy(rx_busy), .tx_busy(tx_busy), .link_en(link_en),
        .PRESCALE(PRESCALE), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .rx_frame_stb(rx_frame_stb), .rx_data(rx_data),
        .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .overflow(overflow), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt),
        .err_clr(err_clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic pe, input logic se);
        rx_frame_stb = 1'b1; rx_data = d; rx_par_err = pe; rx_stp_err = se;
        tick();
        rx_frame_stb = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        RST = 1'b1; cfg_wr = 0; cfg_prescale = 0; cfg_par_en = 0; cfg_par_typ = 0;
        rx_busy = 0; tx_busy = 0; rx_frame_stb = 0; rx_data = 0; rx_par_err = 0;
        rx_stp_err = 0; rd_ready = 0; err_clr = 0;
        tick(); tick();
        RST = 1'b0;

        // reset state
        check("rst_prescale", PRESCALE, 8);
        check("rst_par_en", PAR_EN, 0);
        check("rst_par_typ", PAR_TYP, 0);
        check("rst_link_en", link_en, 1);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_par_cnt", par_err_cnt, 0);
        check("rst_stp_cnt", stp_err_cnt, 0);

        // config change with idle datapaths, cfg_wr at cycle t
        cfg_wr = 1; cfg_prescale = 16; cfg_par_en = 1; cfg_par_typ = 1;
        tick(); cfg_wr = 0;
        check("t1_link_en", link_en, 0);
        check("t1_cfg_busy", cfg_busy, 1);
        check("t1_prescale", PRESCALE, 8);
        tick();
        check("t2_prescale", PRESCALE, 8);
        tick();
        check("t3_prescale", PRESCALE, 16);
        check("t3_par_en", PAR_EN, 1);
        check("t3_par_typ", PAR_TYP, 1);
        check("t3_cfg_busy", cfg_busy, 1);
        tick(); tick(); tick();
        check("t6_cfg_busy", cfg_busy, 1);
        tick();
        check("t7_cfg_busy", cfg_busy, 0);
        check("t7_link_en", link_en, 1);

        // config change while RX busy; second write in DRAIN wins
        rx_busy = 1; cfg_wr = 1; cfg_prescale = 20; cfg_par_en = 0; cfg_par_typ = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cfg_wr = (i == 3);
            if (i == 3) begin cfg_prescale = 32; cfg_par_en = 1; cfg_par_typ = 0; end
            check("drain_prescale", PRESCALE, 16);
            check("drain_link_en", link_en, 0);
        end
        tick(); cfg_wr = 0; rx_busy = 0;
        check("drain_hold", PRESCALE, 16);
        tick();
        check("apply_cyc_prescale", PRESCALE, 16);
        tick();
        check("busy_new_prescale", PRESCALE, 32);
        check("busy_new_par_en", PAR_EN, 1);
        check("busy_new_par_typ", PAR_TYP, 0);
        // cfg_wr in SETTLE must be ignored
        cfg_wr = 1; cfg_prescale = 5; cfg_par_en = 0;
        tick(); cfg_wr = 0;
        tick(); tick(); tick();
        check("settle_exit_busy", cfg_busy, 0);
        tick(); tick(); tick();
        check("settle_wr_ignored", PRESCALE, 32);
        check("settle_wr_idle", cfg_busy, 0);

        // overflow: 5 good frames, depth 4, no pops
        for (int i = 1; i <= 5; i++) begin
            frame(8'(i * 8'h11), 0, 0);
            check("ovf_flag", overflow, (i == 5));
            check("ovf_head", rd_data, 8'h11);
        end
        rd_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_drain_valid", rd_valid, 1);
            check("ovf_drain_data", rd_data, 8'(i * 8'h11));
            tick();
        end
        rd_ready = 0;
        check("ovf_empty", rd_valid, 0);
        check("ovf_sticky", overflow, 1);

        // push and pop in the same cycle while full
        err_clr = 1; tick(); err_clr = 0;
        check("clr_overflow", overflow, 0);
        for (int i = 1; i <= 4; i++) frame(8'hA0 + 8'(i), 0, 0);
        check("full_no_ovf", overflow, 0);
        rd_ready = 1; frame(8'hA5, 0, 0); rd_ready = 0;
        check("pp_no_ovf", overflow, 0);
        check("pp_head", rd_data, 8'hA2);
        frame(8'hA6, 0, 0);
        check("pp_still_full", overflow, 1);
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
        rd_ready = 1;
        foreach (exp_q[i]) begin
            check("pp_drain_data", rd_data, exp_q[i]);
            tick();
        end
        check("pp_empty", rd_valid, 0);
        check("empty_hold", rd_data, 8'hA5);
        tick();
        check("pop_empty_ignored", rd_valid, 0);
        rd_ready = 0;
        frame(8'h77, 0, 0);
        check("after_empty_push", rd_data, 8'h77);
        rd_ready = 1; tick(); rd_ready = 0;
        check("after_empty_pop", rd_valid, 0);

        // error counters
        err_clr = 1; tick(); err_clr = 0;
        check("clr_par", par_err_cnt, 0);
        check("clr_ovf", overflow, 0);
        frame(8'hE1, 1, 0);
        check("par_only_p", par_err_cnt, 1);
        check("par_only_s", stp_err_cnt, 0);
        frame(8'hE2, 0, 1);
        check("stp_only_p", par_err_cnt, 1);
        check("stp_only_s", stp_err_cnt, 1);
        for (int i = 0; i < 300; i++) frame(8'hEE, 1, 1);
        check("sat_par", par_err_cnt, 255);
        check("sat_stp", stp_err_cnt, 255);
        check("err_no_push", rd_valid, 0);
        check("err_no_ovf", overflow, 0);
        err_clr = 1; frame(8'hEF, 1, 1); err_clr = 0;
        check("clr_wins_par", par_err_cnt, 0);
        check("clr_wins_stp", stp_err_cnt, 0);

        // config change with frames buffered
        frame(8'h31, 0, 0); frame(8'h32, 0, 0); frame(8'h33, 0, 0);
        cfg_wr = 1; cfg_prescale = 10; cfg_par_en = 0; cfg_par_typ = 1;
        tick(); cfg_wr = 0;
        check("fl_drain_valid", rd_valid, 1);
        tick();
        check("fl_apply_valid", rd_valid, 1);
        tick();
`ifdef UART_LINK_CTRL_FLUSH_ON_CFG_EN
        check("fl_flushed", rd_valid, 0);
`else
        check("fl_kept_valid", rd_valid, 1);
        check("fl_kept_head", rd_data, 8'h31);
`endif
        check("fl_overflow", overflow, 0);
        tick(); tick(); tick(); tick();
        check("fl_prescale", PRESCALE, 10);
        check("fl_par_typ", PAR_TYP, 1);
        check("fl_cfg_busy", cfg_busy, 0);
        rd_ready = 1; tick(); tick(); tick(); rd_ready = 0;
        check("fl_drained", rd_valid, 0);

        // reset in the middle of DRAIN drops the pending config
        frame(8'h55, 0, 0);
        frame(8'h66, 1, 0);
        rx_busy = 1; cfg_wr = 1; cfg_prescale = 9;
        tick(); cfg_wr = 0;
        check("mid_drain_busy", cfg_busy, 1);
        RST = 1; tick(); RST = 0; rx_busy = 0;
        check("mr_prescale", PRESCALE, 8);
        check("mr_link_en", link_en, 1);
        check("mr_cfg_busy", cfg_busy, 0);
        check("mr_rd_valid", rd_valid, 0);
        check("mr_par_cnt", par_err_cnt, 0);
        tick(); tick(); tick();
        check("mr_no_apply", PRESCALE, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
